// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the multi-cycle ALU.
// The master (control side) drives the request; the slave (ALU) returns
// the registered result, status flags and the BUSY/DONE handshake.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       select;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output start, select, data1, data2,
    input  result, zero, carry, busy, done
  );

  modport slave (
    input  start, select, data1, data2,
    output result, zero, carry, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU behind a START/BUSY/DONE handshake.
// Single-cycle ops (FORWARD/ADD/AND/OR/SUB, shift by 0) finish one edge after
// acceptance; shifts move one bit per cycle; MUL is a WIDTH-step shift-add.
// Optional feature macro: ALU_MUL_EN builds the iterative multiplier; without
// it opcode 111 completes in one cycle with RESULT=0 and CARRY=0.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);

  localparam int CW = SHW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_FWD = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SUB = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  state_t           state_reg, state_next;
  op_t              op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;       // DATA1, also the shifting value
  logic [WIDTH-1:0] b_reg, b_next;       // DATA2
  logic [CW-1:0]    cnt_reg, cnt_next;   // remaining iterations
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, carry_next;
  logic             done_reg, done_next;

  // One-bit shift steps and single-cycle arithmetic on the latched operands
  logic [WIDTH-1:0] sll_val, sra_val;
  logic             sll_out, sra_out;
  logic [WIDTH:0]   add_full, sub_full;

  assign sll_val  = {a_reg[WIDTH-2:0], 1'b0};
  assign sll_out  = a_reg[WIDTH-1];
  assign sra_val  = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
  assign sra_out  = a_reg[0];
  assign add_full = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_full = {1'b0, a_reg} - {1'b0, b_reg};  // MSB is the borrow

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;  // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_reg, mplier_next; // multiplier, shifted right each step
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] acc_sum;

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

  // Control state register; reset aborts any op in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and datapath update; completion writes RESULT/CARRY and pulses DONE
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    carry_next  = carry_reg;
    done_next   = 1'b0;
`ifdef ALU_MUL_EN
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          op_next    = op_t'(bus.select);
          a_next     = bus.data1;
          b_next     = bus.data2;
          state_next = RUN;
          case (op_t'(bus.select))
            OP_SLL, OP_SRA: cnt_next = CW'(bus.data2[SHW-1:0]);
            OP_MUL:         cnt_next = CW'(WIDTH);
            default:        cnt_next = '0;
          endcase
`ifdef ALU_MUL_EN
          mcand_next  = {{WIDTH{1'b0}}, bus.data1};
          mplier_next = bus.data2;
          acc_next    = '0;
`endif
        end
      end
      RUN: begin
        case (op_reg)
          OP_FWD: begin
            result_next = b_reg;
            carry_next  = 1'b0;
            done_next   = 1'b1;
          end
          OP_ADD: begin
            result_next = add_full[WIDTH-1:0];
            carry_next  = add_full[WIDTH];
            done_next   = 1'b1;
          end
          OP_AND: begin
            result_next = a_reg & b_reg;
            carry_next  = 1'b0;
            done_next   = 1'b1;
          end
          OP_OR: begin
            result_next = a_reg | b_reg;
            carry_next  = 1'b0;
            done_next   = 1'b1;
          end
          OP_SUB: begin
            result_next = sub_full[WIDTH-1:0];
            carry_next  = sub_full[WIDTH];
            done_next   = 1'b1;
          end
          OP_SLL, OP_SRA: begin
            if (cnt_reg == '0) begin
              // Zero shift amount: pass DATA1 through with no bit shifted out
              result_next = a_reg;
              carry_next  = 1'b0;
              done_next   = 1'b1;
            end else begin
              a_next   = (op_reg == OP_SLL) ? sll_val : sra_val;
              cnt_next = cnt_reg - CW'(1);
              if (cnt_reg == CW'(1)) begin
                result_next = (op_reg == OP_SLL) ? sll_val : sra_val;
                carry_next  = (op_reg == OP_SLL) ? sll_out : sra_out;
                done_next   = 1'b1;
              end
            end
          end
          default: begin  // OP_MUL
`ifdef ALU_MUL_EN
            acc_next    = acc_sum;
            mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_next    = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
              result_next = acc_sum[WIDTH-1:0];
              carry_next  = |acc_sum[2*WIDTH-1:WIDTH];
              done_next   = 1'b1;
            end
`else
            result_next = '0;
            carry_next  = 1'b0;
            done_next   = 1'b1;
`endif
          end
        endcase
        if (done_next) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers; reset clears everything to the idle values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= OP_FWD;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      done_reg   <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
`endif
    end else begin
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      carry_reg  <= carry_next;
      done_reg   <= done_next;
`ifdef ALU_MUL_EN
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
`endif
    end
  end

  assign bus.result = result_reg;
  assign bus.zero   = (result_reg == '0);
  assign bus.carry  = carry_reg;
  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = done_reg;

endmodule
